// File: rtl/cpu_exec_ctrl.sv
// Execution controller: gates the CPU core clock-enable for free run, single step
// and halt (HALT instruction or PC breakpoint), with a debounced step input.
module cpu_exec_ctrl #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int PC_W            = 16,
  parameter int CNT_W           = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode_run,
  input  logic             step,
  input  logic             resume,
  input  logic             bp_en,
  input  logic [PC_W-1:0]  bp_addr,
  input  logic [PC_W-1:0]  pc,
  input  logic             instr_done,
  input  logic             halt_instr,
  output logic             cpu_en,
  output logic [1:0]       state,
  output logic             halted,
  output logic             bp_hit,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2,
    HALT = 2'd3
  } state_t;

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [SYNC_STAGES-1:0] sync_r;
  logic [DB_W-1:0]        db_cnt_r;
  logic                   filt_r;
  logic                   filt_q_r;
  logic                   sync_out_s;
  logic                   step_pulse_s;
  state_t                 state_r;
  state_t                 state_nxt_s;
  logic                   inc_s;
  logic                   set_bp_s;
  logic                   clr_bp_s;
  logic [CNT_W-1:0]       count_r;
  logic                   bp_hit_r;

  assign sync_out_s   = sync_r[SYNC_STAGES-1];
  assign step_pulse_s = filt_r & ~filt_q_r;

  // Step synchroniser shift chain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_r <= {SYNC_STAGES{1'b0}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], step};
    end
  end

  // Debounce: accept a new level only after DEBOUNCE_CYCLES consecutive mismatches
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_cnt_r <= {DB_W{1'b0}};
      filt_r   <= 1'b0;
      filt_q_r <= 1'b0;
    end else begin
      filt_q_r <= filt_r;
      if (sync_out_s != filt_r) begin
        if (db_cnt_r == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          filt_r   <= sync_out_s;
          db_cnt_r <= {DB_W{1'b0}};
        end else begin
          db_cnt_r <= db_cnt_r + DB_W'(1);
        end
      end else begin
        db_cnt_r <= {DB_W{1'b0}};
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state; on a retire, halt_instr beats breakpoint beats mode change
  always_comb begin
    state_nxt_s = state_r;
    inc_s       = 1'b0;
    set_bp_s    = 1'b0;
    clr_bp_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (mode_run) begin
          state_nxt_s = RUN;
        end else if (step_pulse_s) begin
          state_nxt_s = STEP;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (instr_done) begin
          inc_s = 1'b1;
          if (halt_instr) begin
            state_nxt_s = HALT;
          end else if (bp_en && (pc == bp_addr)) begin
            state_nxt_s = HALT;
            set_bp_s    = 1'b1;
          end else if (!mode_run) begin
            state_nxt_s = IDLE;
          end else begin
            state_nxt_s = RUN;
          end
        end else begin
          state_nxt_s = RUN;
        end
      end
      STEP: begin
        if (instr_done) begin
          inc_s = 1'b1;
          if (halt_instr) begin
            state_nxt_s = HALT;
          end else begin
            state_nxt_s = IDLE;
          end
        end else begin
          state_nxt_s = STEP;
        end
      end
      HALT: begin
        if (resume) begin
          state_nxt_s = IDLE;
          clr_bp_s    = 1'b1;
        end else begin
          state_nxt_s = HALT;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Retired-instruction counter and breakpoint flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r  <= {CNT_W{1'b0}};
      bp_hit_r <= 1'b0;
    end else begin
      if (inc_s) begin
        count_r <= count_r + CNT_W'(1);
      end else begin
        count_r <= count_r;
      end
      if (set_bp_s) begin
        bp_hit_r <= 1'b1;
      end else if (clr_bp_s) begin
        bp_hit_r <= 1'b0;
      end else begin
        bp_hit_r <= bp_hit_r;
      end
    end
  end

  assign cpu_en      = (state_r == RUN) || (state_r == STEP);
  assign halted      = (state_r == HALT);
  assign state       = state_r;
  assign bp_hit      = bp_hit_r;
  assign instr_count = count_r;

endmodule

// File: tb/tb_cpu_exec_ctrl.sv
// Self-checking bench for cpu_exec_ctrl: directed scenarios plus randomized run
// against a behavioural model; a 3-bit counter instance exercises wrap-around.
module tb_cpu_exec_ctrl;

  localparam int SYNC = 2;
  localparam int DEB  = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mode_run = 1'b0, step = 1'b0, resume = 1'b0, bp_en = 1'b0;
  logic        instr_done = 1'b0, halt_instr = 1'b0;
  logic [15:0] bp_addr = 16'h0, pc = 16'h0;

  logic        cpu_en, halted, bp_hit;
  logic [1:0]  state;
  logic [31:0] instr_count;
  logic        cpu_en_w, halted_w, bp_hit_w;
  logic [1:0]  state_w;
  logic [2:0]  instr_count_w;

  int checks = 0;
  int failures = 0;

  cpu_exec_ctrl #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .PC_W(16), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .mode_run(mode_run), .step(step), .resume(resume),
    .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc), .instr_done(instr_done),
    .halt_instr(halt_instr), .cpu_en(cpu_en), .state(state), .halted(halted),
    .bp_hit(bp_hit), .instr_count(instr_count));

  cpu_exec_ctrl #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .PC_W(16), .CNT_W(3)) dut_w (
    .clk(clk), .rst(rst), .mode_run(mode_run), .step(step), .resume(resume),
    .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc), .instr_done(instr_done),
    .halt_instr(halt_instr), .cpu_en(cpu_en_w), .state(state_w), .halted(halted_w),
    .bp_hit(bp_hit_w), .instr_count(instr_count_w));

  always #5 clk = ~clk;

  // Behavioural model: 0=IDLE 1=RUN 2=STEP 3=HALT
  int          m_state;
  int unsigned m_cnt;
  bit          m_bp, m_filt, m_filt_prev;
  int          m_run;
  bit          m_hist[$];

  task automatic model_tick();
    bit s_v, pulse_v, en_v;
    if (rst) begin
      m_state = 0; m_cnt = 0; m_bp = 0; m_filt = 0; m_filt_prev = 0; m_run = 0;
      m_hist = {};
      for (int i = 0; i < SYNC; i++) m_hist.push_back(1'b0);
    end else begin
      s_v     = m_hist[0];
      pulse_v = m_filt && !m_filt_prev;
      en_v    = (m_state == 1) || (m_state == 2);
      if (m_state == 0) begin
        if (mode_run) m_state = 1;
        else if (pulse_v) m_state = 2;
      end else if (m_state == 3) begin
        if (resume) begin m_state = 0; m_bp = 0; end
      end else if (en_v && instr_done) begin
        m_cnt++;
        if (halt_instr) m_state = 3;
        else if (m_state == 1 && bp_en && pc == bp_addr) begin m_state = 3; m_bp = 1; end
        else if (m_state == 2 || !mode_run) m_state = 0;
      end
      m_filt_prev = m_filt;
      if (s_v != m_filt) begin
        m_run++;
        if (m_run == DEB) begin m_filt = s_v; m_run = 0; end
      end else begin
        m_run = 0;
      end
      void'(m_hist.pop_front());
      m_hist.push_back(step);
    end
  endtask

  always @(posedge clk or posedge rst) model_tick();

  task automatic do_reset();
    @(negedge clk);
    mode_run = 0; step = 0; resume = 0; bp_en = 0; instr_done = 0; halt_instr = 0;
    pc = 16'h0; bp_addr = 16'h0;
    rst = 1;
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_random(int n);
    logic en_exp;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      en_exp = (m_state == 1) || (m_state == 2);
      checks++;
      if (state !== m_state[1:0] || instr_count !== m_cnt || bp_hit !== m_bp ||
          cpu_en !== en_exp || halted !== (m_state == 3) || instr_count_w !== m_cnt[2:0]) begin
        failures++;
        $display("FAIL random cyc %0d: state=%0d exp=%0d cnt=%0d exp=%0d bp=%b exp=%b en=%b exp=%b cnt_w=%0d",
                 i, state, m_state, instr_count, m_cnt, bp_hit, m_bp, cpu_en, en_exp, instr_count_w);
      end
      if ($urandom_range(0, 39) == 0) mode_run = ~mode_run;
      if ($urandom_range(0, 11) == 0) step = ~step;
      if ($urandom_range(0, 29) == 0) bp_en = ~bp_en;
      instr_done = ($urandom_range(0, 3) == 0);
      halt_instr = ($urandom_range(0, 7) == 0);
      resume     = ($urandom_range(0, 9) == 0);
      pc         = 16'($urandom_range(0, 7) * 2);
      bp_addr    = 16'h0006;
    end
  endtask

  task automatic test_reset();
    bit ok = 1;
    @(negedge clk);
    #2;
    rst = 1;
    #1;
    checks++;
    if (cpu_en !== 1'b0 || state !== 2'd0 || halted !== 1'b0 || bp_hit !== 1'b0 ||
        instr_count !== 32'd0 || instr_count_w !== 3'd0) begin
      failures++;
      $display("FAIL reset_async: en=%b state=%0d halted=%b bp=%b cnt=%0d required all 0",
               cpu_en, state, halted, bp_hit, instr_count);
    end
    mode_run = 0; step = 0; resume = 0; bp_en = 0; instr_done = 0; halt_instr = 0;
    repeat (5) begin
      @(negedge clk);
      if (state !== 2'd0 || cpu_en !== 1'b0 || instr_count !== 32'd0) ok = 0;
    end
    checks++;
    if (!ok) begin failures++; $display("FAIL reset_hold: state=%0d en=%b required 0/0", state, cpu_en); end
    rst = 0;
  endtask

  task automatic test_single_step();
    bit early = 0;
    bit found = 0;
    do_reset();
    @(negedge clk);
    step = 1;
    repeat (6) begin
      @(negedge clk);
      if (state !== 2'd0 || cpu_en !== 1'b0) early = 1;
    end
    checks++;
    if (early) begin failures++; $display("FAIL step_early: cpu_en rose before edge 7"); end
    @(negedge clk);
    checks++;
    if (state !== 2'd2 || cpu_en !== 1'b1) begin
      failures++; $display("FAIL step_enter: state=%0d en=%b required 2/1", state, cpu_en);
    end
    repeat (2) @(negedge clk);
    instr_done = 1;
    @(negedge clk);
    instr_done = 0;
    checks++;
    if (state !== 2'd0 || cpu_en !== 1'b0 || instr_count !== 32'd1) begin
      failures++; $display("FAIL step_retire: state=%0d en=%b cnt=%0d required 0/0/1", state, cpu_en, instr_count);
    end
    early = 0;
    repeat (12) begin
      @(negedge clk);
      if (state !== 2'd0) early = 1;
    end
    checks++;
    if (early) begin failures++; $display("FAIL step_held: second step while step held"); end
    step = 0;
    repeat (10) @(negedge clk);
    step = 1;
    for (int i = 0; i < 12 && !found; i++) begin
      @(negedge clk);
      if (state == 2'd2) found = 1;
    end
    checks++;
    if (!found) begin failures++; $display("FAIL step_second: state=%0d required 2 within 12 cycles", state); end
    instr_done = 1;
    @(negedge clk);
    instr_done = 0;
    step = 0;
    checks++;
    if (state !== 2'd0 || instr_count !== 32'd2) begin
      failures++; $display("FAIL step_second_retire: state=%0d cnt=%0d required 0/2", state, instr_count);
    end
  endtask

  task automatic test_glitch();
    bit bad = 0;
    do_reset();
    @(negedge clk);
    step = 1;
    repeat (2) @(negedge clk);
    step = 0;
    repeat (15) begin
      @(negedge clk);
      if (state !== 2'd0 || cpu_en !== 1'b0) bad = 1;
    end
    checks++;
    if (bad) begin failures++; $display("FAIL glitch: short pulse accepted, state=%0d", state); end
  endtask

  task automatic test_run_bp();
    logic [15:0] pcs [3] = '{16'h0002, 16'h0004, 16'h0006};
    bit bad = 0;
    do_reset();
    bp_en = 1; bp_addr = 16'h0006; mode_run = 1;
    @(negedge clk);
    checks++;
    if (state !== 2'd1 || cpu_en !== 1'b1) begin
      failures++; $display("FAIL run_enter: state=%0d en=%b required 1/1", state, cpu_en);
    end
    for (int i = 0; i < 3; i++) begin
      pc = pcs[i];
      instr_done = 1;
      @(negedge clk);
      instr_done = 0;
      if (i < 2 && state !== 2'd1) bad = 1;
      if (i < 2) @(negedge clk);
    end
    checks++;
    if (bad) begin failures++; $display("FAIL run_pre_bp: left RUN before breakpoint"); end
    checks++;
    if (state !== 2'd3 || halted !== 1'b1 || bp_hit !== 1'b1 || instr_count !== 32'd3 || cpu_en !== 1'b0) begin
      failures++; $display("FAIL bp_halt: state=%0d halted=%b bp=%b cnt=%0d required 3/1/1/3", state, halted, bp_hit, instr_count);
    end
    @(negedge clk);
    resume = 1;
    @(negedge clk);
    resume = 0;
    checks++;
    if (state !== 2'd0 || bp_hit !== 1'b0) begin
      failures++; $display("FAIL bp_resume: state=%0d bp=%b required 0/0", state, bp_hit);
    end
    @(negedge clk);
    checks++;
    if (state !== 2'd1) begin failures++; $display("FAIL bp_rerun: state=%0d required 1", state); end
    pc = 16'h0008;
    instr_done = 1;
    @(negedge clk);
    instr_done = 0;
    checks++;
    if (state !== 2'd1 || instr_count !== 32'd4) begin
      failures++; $display("FAIL bp_past: state=%0d cnt=%0d required 1/4", state, instr_count);
    end
  endtask

  task automatic test_halt_step();
    bit found = 0;
    bit bad = 0;
    do_reset();
    step = 1;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (state == 2'd2) found = 1;
    end
    checks++;
    if (!found) begin failures++; $display("FAIL halt_step_enter: state=%0d required 2", state); end
    instr_done = 1; halt_instr = 1;
    @(negedge clk);
    instr_done = 0; halt_instr = 0;
    checks++;
    if (state !== 2'd3 || bp_hit !== 1'b0 || halted !== 1'b1 || instr_count !== 32'd1 || cpu_en !== 1'b0) begin
      failures++; $display("FAIL halt_instr: state=%0d bp=%b cnt=%0d required 3/0/1", state, bp_hit, instr_count);
    end
    mode_run = 1; step = 0;
    for (int i = 0; i < 24; i++) begin
      if (i == 10) step = 1;
      @(negedge clk);
      if (state !== 2'd3 || cpu_en !== 1'b0) bad = 1;
    end
    checks++;
    if (bad) begin failures++; $display("FAIL halt_hold: left HALT without resume, state=%0d", state); end
    resume = 1;
    @(negedge clk);
    resume = 0; step = 0;
    checks++;
    if (state !== 2'd0) begin failures++; $display("FAIL halt_resume: state=%0d required 0", state); end
    @(negedge clk);
    checks++;
    if (state !== 2'd1) begin failures++; $display("FAIL halt_rerun: state=%0d required 1", state); end
  endtask

  task automatic test_mode_change();
    bit bad = 0;
    mode_run = 0;
    pc = 16'h0;
    repeat (5) begin
      @(negedge clk);
      if (state !== 2'd1 || cpu_en !== 1'b1) bad = 1;
    end
    checks++;
    if (bad) begin failures++; $display("FAIL mode_midinstr: left RUN without retire, state=%0d", state); end
    instr_done = 1;
    @(negedge clk);
    instr_done = 0;
    checks++;
    if (state !== 2'd0 || cpu_en !== 1'b0 || instr_count !== 32'd2) begin
      failures++; $display("FAIL mode_boundary: state=%0d en=%b cnt=%0d required 0/0/2", state, cpu_en, instr_count);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    mode_run = 1;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      instr_done = 1;
      @(negedge clk);
      instr_done = 0;
      if (i == 6) begin
        checks++;
        if (instr_count_w !== 3'd7) begin
          failures++; $display("FAIL wrap_allones: cnt_w=%0d required 7", instr_count_w);
        end
      end
    end
    checks++;
    if (instr_count_w !== 3'd0 || instr_count !== 32'd8 || state !== 2'd1) begin
      failures++; $display("FAIL wrap_zero: cnt_w=%0d cnt=%0d state=%0d required 0/8/1", instr_count_w, instr_count, state);
    end
  endtask

  initial begin
    #2 rst = 1;
    @(negedge clk);
    rst = 0;
    test_random(60);
    test_reset();
    test_single_step();
    test_glitch();
    test_run_bp();
    test_halt_step();
    test_mode_change();
    test_wrap();
    test_random(3000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_exec_ctrl.md
Name: cpu_exec_ctrl

Overview:
- Execution controller placed between the board/testbench controls (mode_run, step) and the CPU core.
- Gates the core with a clock-enable so it runs freely, executes exactly one instruction per step press, or halts on a HALT instruction or a PC breakpoint.
- Synchronises and debounces the raw step input and keeps a retired-instruction counter for debug.

Parameters:
SYNC_STAGES, 2, flops in the step input synchroniser (>=2)
DEBOUNCE_CYCLES, 4, consecutive stable synchronised cycles needed to accept a step level change (>=1)
PC_W, 16, width of pc and bp_addr
CNT_W, 32, width of instr_count

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
mode_run  in  1  1 = continuous run, 0 = step mode; synchronous level
step  in  1  raw asynchronous step button/level
resume  in  1  synchronous one-cycle pulse: leave HALT
bp_en  in  1  breakpoint enable
bp_addr  in  PC_W  breakpoint address
pc  in  PC_W  core PC; holds next-instruction address when instr_done=1
instr_done  in  1  core pulse: instruction retired this cycle
halt_instr  in  1  retired instruction was HALT; valid only with instr_done
cpu_en  out  1  clock-enable to core
state  out  2  0=IDLE, 1=RUN, 2=STEP, 3=HALT
halted  out  1  1 while state==HALT
bp_hit  out  1  HALT was entered by breakpoint
instr_count  out  CNT_W  retired instructions, wraps modulo 2^CNT_W

Behaviour:
- Reset (async, immediate): state=IDLE, cpu_en=0, halted=0, bp_hit=0, instr_count=0; synchroniser, debounce counter and filtered level cleared to 0.
- Step conditioning:
  - step passes through SYNC_STAGES flops, giving s.
  - The debounce counter increments each cycle s != filt, and clears on any cycle s == filt.
  - On the DEBOUNCE_CYCLES-th consecutive mismatch edge: filt <= s, counter <= 0.
  - step_pulse = filt & ~filt_q (single cycle per rising edge of filt).
  - A raw high first sampled at edge 1 makes filt=1 after edge SYNC_STAGES+DEBOUNCE_CYCLES; the state transition occurs at the next edge.
  - Defaults: cpu_en rises after edge 7.
  - Pulses shorter than DEBOUNCE_CYCLES synchronised cycles are rejected.
- cpu_en = (state==RUN) | (state==STEP), decoded from the state register. instr_done and halt_instr are ignored while cpu_en=0.
- FSM, one transition per edge. Priority within RUN/STEP on an instr_done cycle: halt_instr > breakpoint > mode check.
  - IDLE: mode_run=1 -> RUN; else step_pulse -> STEP; else stay.
  - RUN: on instr_done, instr_count+1, then:
    - halt_instr -> HALT;
    - else bp_en & pc==bp_addr -> HALT with bp_hit<=1;
    - else mode_run=0 -> IDLE;
    - else stay.
    - Without instr_done, stay in RUN even if mode_run=0; mode changes take effect only at instruction boundaries.
  - STEP: on instr_done, instr_count+1, then halt_instr -> HALT, else -> IDLE. The breakpoint is not checked. step_pulse and mode_run are ignored while in STEP.
  - HALT: cpu_en=0, halted=1. resume -> IDLE and bp_hit<=0. step_pulse and mode_run are ignored.
- After resume, with mode_run=1, IDLE -> RUN on the next edge. Resuming with pc==bp_addr does not re-trigger, because the compare occurs only at the next retire, with the new pc.
- bp_hit is set only on breakpoint entry to HALT and cleared only by resume or rst.
- instr_count wraps from all-ones to 0 with no flag.
- rst mid-instruction drops cpu_en immediately; no retire is counted.

Test Plan:
1. Reset: assert rst 5 cycles at arbitrary state -> cpu_en=0, state=0, halted=0, bp_hit=0, instr_count=0 during reset, without waiting for a clock edge.
2. Single step: mode_run=0, raw step high for 20 cycles -> state=2 and cpu_en=1 after exactly edge 7. instr_done pulse 3 cycles later -> state=0 next edge, cpu_en=0, instr_count=1. No second step while step stays high; a release plus a new press of >=4 synced cycles gives instr_count=2.
3. Glitch rejection: step high for 2 cycles, then low -> state stays 0, cpu_en never asserts.
4. Run + breakpoint: bp_en=1, bp_addr=0x0006, mode_run=1. Retires with pc=0x0002, 0x0004, 0x0006 -> HALT after the third: state=3, halted=1, bp_hit=1, instr_count=3. resume pulse -> state=0, bp_hit=0, then state=1 next edge. Retire with pc=0x0008 -> stays RUN.
5. HALT instruction in step mode: STEP entered, instr_done=1 with halt_instr=1 -> state=3, bp_hit=0. Further step presses and mode_run=1 -> no change until resume.
6. Mode change mid-instruction: in RUN drop mode_run; cpu_en stays 1 until instr_done, then state=0. Also instr_count preset near 2^CNT_W-1 (force) + 1 retire -> 0.
